// File: rtl/rv32_pkg.sv
// Shared RV32I core types and constants.
// Used by the fetch stage (instr_fetch_unit) and its PC register.
package rv32_pkg;

    typedef enum logic {
        PC_PC4 = 1'b0,
        PC_ALU = 1'b1
    } PCSel_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // ALU targets have bit 0 cleared, as for JALR.
    function automatic logic [31:0] calc_next_pc(
        input PCSel_t      sel,
        input logic [31:0] pc,
        input logic [31:0] alu
    );
        if (sel == PC_ALU) begin
            return alu & 32'hFFFF_FFFE;
        end
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register of the fetch stage.
// Synchronous active-high reset to RESET_PC; loads on i_load.
import rv32_pkg::*;

module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_next_pc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // PC update: reset wins, otherwise load the selected next PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, req/gnt/rvalid fetch, inst hold.
// IFETCH_MISALIGN_CHK_EN: halt with sticky misalign_err on bit-1 targets.
import rv32_pkg::*;

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  PCSel_t      PCSel,
    input  logic [31:0] ALU_out,
    input  logic        inst_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        misalign_err
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_inst;
    logic [31:0]  w_pc;
    logic [31:0]  w_next_pc;
    logic         w_ack_fire;
    logic         w_misalign;

    assign w_ack_fire = inst_ack && (r_state == S_HOLD);
    assign w_next_pc  = calc_next_pc(PCSel, w_pc, ALU_out);

`ifdef IFETCH_MISALIGN_CHK_EN
    assign w_misalign = w_next_pc[1];
`else
    assign w_misalign = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_ack_fire),
        .i_next_pc (w_next_pc),
        .o_pc      (w_pc)
    );

    // Next-state: stray gnt/rvalid outside their states are ignored.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_ack_fire) begin
                    w_state_nxt = w_misalign ? S_HALT : S_REQ;
                end
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; a reset abandons any fetch in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction capture, only for the response awaited in S_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst <= INSTR_NOP;
        end else if (r_state == S_WAIT && imem_rvalid) begin
            r_inst <= imem_rdata;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic r_misalign;

    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_ack_fire && w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = w_pc;
    assign inst       = r_inst;
    assign inst_valid = (r_state == S_HOLD);
    assign PC         = w_pc;
    assign PC4        = w_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (directed + random fetches).
// Reference keeps the expected PC/inst with plain next-PC arithmetic.
import rv32_pkg::*;

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    PCSel_t      PCSel;
    logic [31:0] ALU_out;
    logic        inst_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        misalign_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PCSel        (PCSel),
        .ALU_out      (ALU_out),
        .inst_ack     (inst_ack),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .PC           (PC),
        .PC4          (PC4),
        .misalign_err (misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        inst_ack = 1'b0;
        step();
        step();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, INSTR_NOP);
        chk("rst_pc", PC, DEFAULT_RESET_PC);
        chk("rst_misalign", misalign_err, 1'b0);
        rst = 1'b0;
        exp_pc = DEFAULT_RESET_PC;
        exp_inst = INSTR_NOP;
        step();
    endtask

    // Entered in S_REQ; leaves the DUT in S_HOLD with word captured.
    task automatic fetch(input logic [31:0] word, input int gd,
                         input int rd, input bit stray);
        chk("req", imem_req, 1'b1);
        chk("addr", imem_addr, exp_pc);
        chk("valid_req", inst_valid, 1'b0);
        for (int i = 0; i < gd; i++) begin
            imem_gnt = 1'b0;
            step();
            chk("req_stall", imem_req, 1'b1);
            chk("addr_stall", imem_addr, exp_pc);
            chk("valid_stall", inst_valid, 1'b0);
        end
        imem_gnt = 1'b1;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata = ~word;
        end
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        chk("req_wait", imem_req, 1'b0);
        for (int i = 0; i < rd; i++) begin
            if (stray) imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0;
            chk("valid_wait", inst_valid, 1'b0);
        end
        imem_rvalid = 1'b1;
        imem_rdata = word;
        step();
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        exp_inst = word;
        chk("valid_hold", inst_valid, 1'b1);
        chk("inst_hold", inst, exp_inst);
        chk("pc_hold", PC, exp_pc);
        chk("pc4_hold", PC4, exp_pc + 32'd4);
        chk("req_hold", imem_req, 1'b0);
    endtask

    // Entered in S_HOLD; acks after hold cycles, model updates PC.
    task automatic retire(input bit sel, input logic [31:0] alu,
                          input int hold, input bit stray);
        for (int i = 0; i < hold; i++) begin
            if (stray) begin
                imem_rvalid = 1'b1;
                imem_gnt = 1'b1;
                imem_rdata = $urandom;
            end
            step();
            imem_rvalid = 1'b0;
            imem_gnt = 1'b0;
            chk("valid_keep", inst_valid, 1'b1);
            chk("inst_keep", inst, exp_inst);
            chk("pc_keep", PC, exp_pc);
        end
        inst_ack = 1'b1;
        PCSel = sel ? PC_ALU : PC_PC4;
        ALU_out = alu;
        step();
        inst_ack = 1'b0;
        PCSel = PC_PC4;
        ALU_out = $urandom;
        if (sel) exp_pc = {alu[31:1], 1'b0};
        else exp_pc = exp_pc + 32'd4;
        chk("valid_ack", inst_valid, 1'b0);
        chk("pc_ack", PC, exp_pc);
    endtask

    initial begin
        logic [31:0] alu;
        PCSel = PC_PC4;
        ALU_out = '0;
        imem_rdata = '0;

        // 1: reset and best-case fetch
        do_reset();
        fetch(32'h0050_0093, 0, 0, 1'b0);

        // 2: sequential and ALU-selected next PC
        retire(1'b0, 32'h0, 0, 1'b0);
        chk("t2_addr4", imem_addr, 32'h4);
        fetch(32'h0000_0113, 0, 1, 1'b0);
        retire(1'b1, 32'h0000_0101, 0, 1'b0);
        chk("t2_addr100", imem_addr, 32'h0000_0100);

        // 3: grant withheld for 5 cycles
        fetch(32'h1234_5678, 5, 0, 1'b0);
        retire(1'b0, 32'h0, 1, 1'b0);

        // 4: ack while not valid, stray rvalid while holding
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        inst_ack = 1'b1;
        PCSel = PC_ALU;
        ALU_out = 32'h0000_0500;
        step();
        inst_ack = 1'b0;
        PCSel = PC_PC4;
        chk("t4_pc_noack", PC, exp_pc);
        chk("t4_valid", inst_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hCAFE_0013;
        step();
        exp_inst = 32'hCAFE_0013;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("t4_inst_stray", inst, exp_inst);
        chk("t4_pc_stray", PC, exp_pc);
        chk("t4_valid_stray", inst_valid, 1'b1);

        // PC+4 wrap at the top of the address space
        retire(1'b1, 32'hFFFF_FFFC, 0, 1'b0);
        fetch(32'h0000_0093, 0, 0, 1'b0);
        chk("wrap_pc4", PC4, 32'h0000_0000);
        retire(1'b0, 32'h0, 0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // random fetch/retire traffic
        for (int n = 0; n < 24; n++) begin
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
            alu = $urandom;
`ifdef IFETCH_MISALIGN_CHK_EN
            alu[1] = 1'b0;
`endif
            retire(1'($urandom_range(0, 1)), alu, $urandom_range(0, 2),
                   1'($urandom_range(0, 1)));
            chk("rnd_addr", imem_addr, exp_pc);
        end

        // 5: reset during S_WAIT
        fetch(32'h00A0_0093, 0, 0, 1'b0);
        retire(1'b1, 32'h0000_0800, 0, 1'b0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        rst = 1'b0;
        imem_rvalid = 1'b0;
        chk("t5_pc", PC, DEFAULT_RESET_PC);
        chk("t5_inst", inst, INSTR_NOP);
        chk("t5_valid", inst_valid, 1'b0);
        step();
        exp_pc = DEFAULT_RESET_PC;
        chk("t5_req", imem_req, 1'b1);
        chk("t5_addr", imem_addr, DEFAULT_RESET_PC);

        // 6: misaligned ALU target
        fetch(32'h0000_0013, 0, 0, 1'b0);
        retire(1'b1, 32'h0000_0006, 0, 1'b0);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("t6_misalign", misalign_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            imem_gnt = 1'b1;
            imem_rvalid = 1'b1;
            step();
            chk("t6_halt_req", imem_req, 1'b0);
            chk("t6_halt_valid", inst_valid, 1'b0);
            chk("t6_sticky", misalign_err, 1'b1);
        end
        do_reset();
        chk("t6_restart", imem_req, 1'b1);
`else
        chk("t6_addr", imem_addr, 32'h0000_0006);
        chk("t6_misalign", misalign_err, 1'b0);
        fetch(32'h0010_0093, 1, 0, 1'b0);
        chk("t6_misalign_hold", misalign_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
